filter_frame_sequencer: RTL and testbench
=========================================

Name: filter_frame_sequencer

Overview:
- Frame-level controller that sequences one grayscale frame from a pixel memory through a streaming 3x3 window filter (Laplacian/Sobel class: two line buffers, no ready input, consumes a pixel every cycle its valid is high).
- Generates read addresses and the filter's pixel_valid stream, and clears the filter's row/column state before each frame.
- Honours a downstream stall, counts filter results against the expected count, and reports done and frame_ok.
- Sits between the frame-buffer read port and the filter instance.

Parameters:
- IMG_W, 256, frame width in pixels (≥3); must match the filter's IMG_W.
- IMG_H, 256, frame height in rows (≥3).
- ADDR_W, 16, memory address width; IMG_W*IMG_H ≤ 2^ADDR_W.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  frame start request; sampled only in IDLE.
- abort  in  1  cancel the current frame.
- sink_ready  in  1  downstream can accept results; low stalls the stream.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_W  read address, linear raster order.
- mem_rd_data  in  8  read data, valid exactly 1 cycle after mem_rd_en.
- flt_rst  out  1  one-cycle clear pulse to the filter's rst.
- flt_pixel  out  8  pixel to the filter; combinational passthrough of mem_rd_data.
- flt_valid  out  1  pixel_valid to the filter; mem_rd_en delayed 1 cycle.
- flt_out_valid  in  1  the filter's out_valid.
- busy  out  1  high in CLEAR, STREAM and DRAIN.
- done  out  1  one-cycle pulse at end of frame.
- frame_ok  out  1  valid with done; 1 iff result count == (IMG_H-2)*(IMG_W-2).
- out_count  out  ADDR_W  filter results counted in the current frame.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high and overrides everything.
- Reset values: state IDLE; mem_rd_en=0, mem_addr=0, flt_valid=0, flt_rst=0, busy=0, done=0, frame_ok=0, out_count=0.
- States: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE:
  - start=1 -> CLEAR.
  - Also on start=1: out_count:=0, mem_addr:=0.
- CLEAR:
  - flt_rst=1 for exactly this cycle.
  - Next state is STREAM.
- STREAM:
  - mem_rd_en = sink_ready (combinational AND with state).
  - Each cycle with mem_rd_en=1, mem_addr increments by 1.
  - The read with mem_addr == IMG_W*IMG_H-1 moves the state to DRAIN.
  - sink_ready=0 issues no read, holds mem_addr, and the FSM stays in STREAM.
  - A read already in flight still produces flt_valid next cycle, because the filter cannot stall.
  - The sink must absorb up to 2 results after dropping sink_ready.
- DRAIN:
  - Lasts exactly 2 cycles (2-bit counter), covering the last flt_valid and the filter's registered output.
  - No reads are issued. Next state is DONE.
- DONE:
  - done=1 and frame_ok is driven for this one cycle.
  - busy=0. Next state is IDLE.
  - out_count holds its value until the next start.
- out_count:
  - Increments on every cycle with flt_out_valid=1 while in STREAM or DRAIN.
  - Saturates at its maximum value; no wrap.
- flt_valid:
  - Registered copy of mem_rd_en.
  - Forced to 0 on abort and on reset.
- abort:
  - In CLEAR, STREAM or DRAIN: next state is IDLE, flt_rst pulses for 1 cycle, no done, and the in-flight flt_valid is suppressed.
  - In IDLE or DONE, abort is ignored.
  - abort takes priority over start and over a simultaneous last read.
- start while busy is ignored (no restart, no error).
- Simultaneous start in the DONE cycle is ignored; start must be re-asserted in IDLE.
- Reset mid-frame behaves like abort except that flt_rst is not driven. The filter is reset through its own reset tree, and the next CLEAR clears it anyway.

Decomposition:
- Shared package img_pkg:
  - State enum (IDLE, CLEAR, STREAM, DRAIN, DONE).
  - Constant DRAIN_CYCLES=2.
  - Function for the expected-result count, (H-2)*(W-2), reused by the filter bench and other kernels.
- One natural sub-module: raster_addr_gen.
  - Linear address counter with enable, clear and last flag.
  - The FSM, count and handshake logic stay in the top level.

Test Plan:
- Nominal frame: IMG_W=4, IMG_H=4, sink_ready=1, start pulsed in cycle 0.
  - Cycle 1: flt_rst=1.
  - Cycles 2-17: mem_rd_en=1, addresses 0..15.
  - Cycles 3-18: flt_valid=1.
  - Cycle 20: done=1, frame_ok=1, out_count=4.
- Stall: as nominal, sink_ready=0 during cycles 6-8.
  - No reads in cycles 6-8; mem_addr holds at 4.
  - Addresses stay contiguous with none skipped or repeated.
  - done in cycle 23, out_count=4.
- Abort: abort=1 in cycle 10 of the nominal frame.
  - Cycle 11: state IDLE, flt_rst=1, flt_valid=0.
  - done never pulses.
  - A new start then runs a clean frame with out_count=4.
- Start while busy: start pulses in cycles 0 and 5.
  - Only one frame runs; a single done in cycle 20.
- Count mismatch: the bench model suppresses one flt_out_valid.
  - done=1 with frame_ok=0 and out_count=3.
- Reset mid-frame: rst=1 in cycle 9.
  - Next cycle: all outputs at their reset values.
  - A following start gives a normal frame, done and frame_ok=1.

Source files
------------

// File: rtl/img_pkg.sv
// ----------------------------------------------------------------------------
// img_pkg
// Shared definitions for the image-filter frame path.
//   seq_state_e       : frame sequencer states
//   DRAIN_CYCLES      : cycles spent flushing the filter after the last read
//   expected_results(): number of valid 3x3 window outputs for a W x H frame
// ----------------------------------------------------------------------------
package img_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StClear  = 3'd1,
        StStream = 3'd2,
        StDrain  = 3'd3,
        StDone   = 3'd4
    } seq_state_e;

    // Covers the last pixel_valid plus the filter's registered output stage.
    localparam int unsigned DRAIN_CYCLES = 2;

    // A 3x3 window produces no output on the first two rows and columns.
    function automatic int unsigned expected_results(input int unsigned w,
                                                     input int unsigned h);
        return (h - 2) * (w - 2);
    endfunction

endpackage

// File: rtl/raster_addr_gen.sv
// ----------------------------------------------------------------------------
// raster_addr_gen
// Linear raster-order read address counter.
// Ports:
//   i_clk    : clock
//   i_rst    : synchronous active-high reset (address -> 0)
//   i_clear  : restart the frame at address 0
//   i_en     : advance the address by one this cycle
//   o_addr   : current read address
//   o_last   : current address is the last pixel of the frame
// ----------------------------------------------------------------------------
module raster_addr_gen #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned TOTAL  = 65536
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_en,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

    logic [ADDR_W-1:0] r_addr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr <= '0;
        end else if (i_clear) begin
            r_addr <= '0;
        end else if (i_en) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_addr == LAST_ADDR);

endmodule

// File: rtl/filter_frame_sequencer.sv
// ----------------------------------------------------------------------------
// filter_frame_sequencer
// Streams one grayscale frame from a pixel memory into a 3x3 window filter,
// clearing the filter first, honouring a downstream stall and counting the
// filter results against the expected count.
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_start             : frame start request (IDLE only)
//   i_abort             : cancel the frame in CLEAR/STREAM/DRAIN
//   i_sink_ready        : downstream ready; low stops new reads
//   o_mem_rd_en/o_mem_addr, i_mem_rd_data : memory read port (1-cycle latency)
//   o_flt_rst           : one-cycle clear pulse to the filter
//   o_flt_pixel         : pixel to the filter (passthrough of read data)
//   o_flt_valid         : pixel_valid to the filter (read strobe delayed 1)
//   i_flt_out_valid     : filter result strobe
//   o_busy              : frame in progress (CLEAR/STREAM/DRAIN)
//   o_done, o_frame_ok  : end-of-frame pulse and result-count check
//   o_out_count         : results counted in the current frame
// ----------------------------------------------------------------------------
module filter_frame_sequencer
    import img_pkg::*;
#(
    parameter int unsigned IMG_W  = 256,
    parameter int unsigned IMG_H  = 256,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_sink_ready,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [7:0]        i_mem_rd_data,
    output logic              o_flt_rst,
    output logic [7:0]        o_flt_pixel,
    output logic              o_flt_valid,
    input  logic              i_flt_out_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_frame_ok,
    output logic [ADDR_W-1:0] o_out_count
);

    localparam logic [ADDR_W-1:0] EXP_COUNT = ADDR_W'(expected_results(IMG_W, IMG_H));
    localparam logic [1:0]        DRAIN_END = 2'(DRAIN_CYCLES - 1);

    seq_state_e        r_state;
    seq_state_e        w_state_next;
    logic [1:0]        r_drain_cnt;
    logic              r_flt_valid;
    logic              r_flt_rst;
    logic [ADDR_W-1:0] r_out_count;

    logic              w_rd_en;
    logic              w_addr_last;
    logic              w_busy;
    logic              w_start_hit;
    logic              w_abort_hit;
    logic              w_counting;

    assign w_start_hit = i_start && (r_state == StIdle);
    assign w_abort_hit = i_abort && w_busy;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state (abort wins over start and over the last read)
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:   if (i_start) w_state_next = StClear;
            StClear:  w_state_next = StStream;
            StStream: if (w_rd_en && w_addr_last) w_state_next = StDrain;
            StDrain:  if (r_drain_cnt == DRAIN_END) w_state_next = StDone;
            StDone:   w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
        if (w_abort_hit) begin
            w_state_next = StIdle;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_en    = 1'b0;
        w_busy     = 1'b0;
        w_counting = 1'b0;
        o_done     = 1'b0;
        o_frame_ok = 1'b0;
        case (r_state)
            StClear: begin
                w_busy = 1'b1;
            end
            StStream: begin
                w_busy     = 1'b1;
                w_rd_en    = i_sink_ready;
                w_counting = 1'b1;
            end
            StDrain: begin
                w_busy     = 1'b1;
                w_counting = 1'b1;
            end
            StDone: begin
                o_done     = 1'b1;
                o_frame_ok = (r_out_count == EXP_COUNT);
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_drain_cnt <= '0;
        end else if (r_state != StDrain) begin
            r_drain_cnt <= '0;
        end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
        end
    end

    // The filter cannot stall, so a read issued this cycle always becomes a
    // pixel_valid next cycle unless the frame is being abandoned.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_flt_valid <= 1'b0;
        end else begin
            r_flt_valid <= w_rd_en && !w_abort_hit;
        end
    end

    // Registered so the pulse lands in CLEAR, or in the first IDLE cycle
    // after an abort.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_flt_rst <= 1'b0;
        end else begin
            r_flt_rst <= w_start_hit || w_abort_hit;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_count <= '0;
        end else if (w_start_hit) begin
            r_out_count <= '0;
        end else if (i_flt_out_valid && w_counting && (r_out_count != '1)) begin
            r_out_count <= r_out_count + 1'b1;
        end
    end

    raster_addr_gen #(
        .ADDR_W (ADDR_W),
        .TOTAL  (IMG_W * IMG_H)
    ) u_addr_gen (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (w_start_hit),
        .i_en    (w_rd_en),
        .o_addr  (o_mem_addr),
        .o_last  (w_addr_last)
    );

    assign o_mem_rd_en = w_rd_en;
    assign o_flt_pixel = i_mem_rd_data;
    assign o_flt_valid = r_flt_valid;
    assign o_flt_rst   = r_flt_rst;
    assign o_busy      = w_busy;
    assign o_out_count = r_out_count;

endmodule

// File: tb/tb_filter_frame_sequencer.sv
// ----------------------------------------------------------------------------
// tb_filter_frame_sequencer
// Directed bench for filter_frame_sequencer on a 4x4 frame. A memory model
// returns a known pattern per address, a queue holds the pixel expected for
// each issued read, and a small filter model raises out_valid one cycle after
// each pixel whose 3x3 window is complete.
// ----------------------------------------------------------------------------
module tb_filter_frame_sequencer;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 4;
    localparam int unsigned AW = 16;

    logic          clk;
    logic          i_rst;
    logic          i_start;
    logic          i_abort;
    logic          i_sink_ready;
    logic          o_mem_rd_en;
    logic [AW-1:0] o_mem_addr;
    logic [7:0]    i_mem_rd_data;
    logic          o_flt_rst;
    logic [7:0]    o_flt_pixel;
    logic          o_flt_valid;
    logic          i_flt_out_valid;
    logic          o_busy;
    logic          o_done;
    logic          o_frame_ok;
    logic [AW-1:0] o_out_count;

    filter_frame_sequencer #(
        .IMG_W  (W),
        .IMG_H  (H),
        .ADDR_W (AW)
    ) dut (
        .i_clk           (clk),
        .i_rst           (i_rst),
        .i_start         (i_start),
        .i_abort         (i_abort),
        .i_sink_ready    (i_sink_ready),
        .o_mem_rd_en     (o_mem_rd_en),
        .o_mem_addr      (o_mem_addr),
        .i_mem_rd_data   (i_mem_rd_data),
        .o_flt_rst       (o_flt_rst),
        .o_flt_pixel     (o_flt_pixel),
        .o_flt_valid     (o_flt_valid),
        .i_flt_out_valid (i_flt_out_valid),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_frame_ok      (o_frame_ok),
        .o_out_count     (o_out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int done_cnt;

    // Snapshot of DUT outputs taken at the falling edge of each cycle.
    logic          s_rd_en, s_flt_rst, s_flt_valid, s_busy, s_done, s_ok;
    logic [AW-1:0] s_addr, s_count;
    logic [7:0]    s_pixel;

    logic [7:0]  sb_q[$];
    int unsigned m_addr;
    int unsigned px_idx;
    bit          drop_pending;
    bit          next_fov;

    function automatic logic [7:0] pat(input int unsigned a);
        return 8'((a * 37 + 5) & 255);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic frame_setup(input bit drop);
        m_addr       = 0;
        done_cnt     = 0;
        drop_pending = drop;
        sb_q.delete();
    endtask

    // One clock cycle: drive inputs, sample at negedge, run scoreboard and
    // models, then update model-driven inputs just after the rising edge.
    task automatic run_cycle(input bit st, input bit ab, input bit sr, input bit rs);
        logic [7:0] exp_px;
        i_start      = st;
        i_abort      = ab;
        i_sink_ready = sr;
        i_rst        = rs;
        @(negedge clk);
        s_rd_en     = o_mem_rd_en;
        s_addr      = o_mem_addr;
        s_flt_rst   = o_flt_rst;
        s_flt_valid = o_flt_valid;
        s_pixel     = o_flt_pixel;
        s_busy      = o_busy;
        s_done      = o_done;
        s_ok        = o_frame_ok;
        s_count     = o_out_count;

        if (s_flt_valid) begin
            chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                exp_px = sb_q.pop_front();
                chk("flt_pixel", 32'(s_pixel), 32'(exp_px));
            end
        end
        if (s_rd_en) begin
            chk("mem_addr", 32'(s_addr), 32'(m_addr));
            sb_q.push_back(pat(m_addr));
            m_addr++;
        end

        next_fov = 1'b0;
        if (s_flt_rst) px_idx = 0;
        if (s_flt_valid) begin
            if ((px_idx / W) >= 2 && (px_idx % W) >= 2) begin
                if (drop_pending) drop_pending = 1'b0;
                else next_fov = 1'b1;
            end
            px_idx++;
        end
        if (s_done) done_cnt++;
        if ((ab && s_busy) || rs) sb_q.delete();

        @(posedge clk);
        #1;
        i_mem_rd_data   = s_rd_en ? pat(int'(s_addr)) : 8'h00;
        i_flt_out_valid = next_fov && !rs;
        if (rs) px_idx = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".rd_en"},    32'(s_rd_en),     32'd0);
        chk({tag, ".addr"},     32'(s_addr),      32'd0);
        chk({tag, ".flt_valid"},32'(s_flt_valid), 32'd0);
        chk({tag, ".flt_rst"},  32'(s_flt_rst),   32'd0);
        chk({tag, ".busy"},     32'(s_busy),      32'd0);
        chk({tag, ".done"},     32'(s_done),      32'd0);
        chk({tag, ".frame_ok"}, 32'(s_ok),        32'd0);
        chk({tag, ".count"},    32'(s_count),     32'd0);
    endtask

    // Full frame starting in IDLE at c=0, with optional stall window, extra
    // start pulse while busy, and one suppressed filter result.
    task automatic frame_run(input string tag, input int stall_lo, input int stall_hi,
                             input int extra_start, input bit drop);
        int stall_len;
        int exp_done;
        bit sr;
        bit exp_rd;
        bit prev_rd;
        stall_len = (stall_lo >= 0) ? (stall_hi - stall_lo + 1) : 0;
        exp_done  = 20 + stall_len;
        prev_rd   = 1'b0;
        frame_setup(drop);
        for (int c = 0; c <= exp_done + 2; c++) begin
            sr     = !(c >= stall_lo && c <= stall_hi);
            exp_rd = sr && c >= 2 && c <= 17 + stall_len;
            run_cycle(c == 0 || c == extra_start, 1'b0, sr, 1'b0);
            chk({tag, ".flt_rst"},   32'(s_flt_rst),   32'(c == 1));
            chk({tag, ".rd_en"},     32'(s_rd_en),     32'(exp_rd));
            chk({tag, ".flt_valid"}, 32'(s_flt_valid), 32'(prev_rd));
            chk({tag, ".busy"},      32'(s_busy),      32'(c >= 1 && c < exp_done));
            chk({tag, ".done"},      32'(s_done),      32'(c == exp_done));
            if (!sr) chk({tag, ".stall_addr"}, 32'(s_addr), 32'(stall_lo - 2));
            if (c == exp_done) begin
                chk({tag, ".frame_ok"}, 32'(s_ok),        32'(!drop));
                chk({tag, ".count"},    32'(s_count),     drop ? 32'd3 : 32'd4);
                chk({tag, ".sb_empty"}, 32'(sb_q.size()), 32'd0);
            end
            prev_rd = exp_rd;
        end
        chk({tag, ".done_cnt"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        i_mem_rd_data   = 8'h00;
        i_flt_out_valid = 1'b0;
        px_idx          = 0;
        frame_setup(1'b0);

        // Reset state
        run_cycle(1'b0, 1'b0, 1'b1, 1'b1);
        run_cycle(1'b0, 1'b0, 1'b1, 1'b1);
        run_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk_reset_vals("reset");

        // Nominal frame
        frame_run("nominal", -1, -1, -1, 1'b0);

        // Downstream stall in cycles 6-8
        frame_run("stall", 6, 8, -1, 1'b0);

        // Start while busy is ignored
        frame_run("busy_start", -1, -1, 5, 1'b0);

        // One filter result lost
        frame_run("mismatch", -1, -1, -1, 1'b1);

        // Abort in cycle 10
        frame_setup(1'b0);
        for (int c = 0; c <= 24; c++) begin
            run_cycle(c == 0, c == 10, 1'b1, 1'b0);
            chk("abort.done", 32'(s_done), 32'd0);
            if (c == 11) begin
                chk("abort.flt_rst",   32'(s_flt_rst),   32'd1);
                chk("abort.flt_valid", 32'(s_flt_valid), 32'd0);
                chk("abort.busy",      32'(s_busy),      32'd0);
                chk("abort.rd_en",     32'(s_rd_en),     32'd0);
            end
        end
        chk("abort.done_cnt", 32'(done_cnt), 32'd0);
        frame_run("post_abort", -1, -1, -1, 1'b0);

        // Reset in cycle 9
        frame_setup(1'b0);
        for (int c = 0; c <= 9; c++) begin
            run_cycle(c == 0, 1'b0, 1'b1, c == 9);
        end
        run_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk_reset_vals("mid_rst");
        run_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        frame_run("post_rst", -1, -1, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
